// File: rtl/passthru_mc.sv
// -----------------------------------------------------------------------------
// passthru_mc
//   Multi-channel differential passthrough. Every rx line is synchronised into
//   fxclk and glitch-filtered. The filtered pairs drive the registered tx pins
//   under a run-time mode. Per channel, the block also keeps a sticky flag for
//   invalid (p == n) filtered states and a saturating count of rising edges on
//   the filtered positive line.
//
// Ports
//   fxclk     in   1            system clock
//   reset_n   in   1            synchronous, active-low reset
//   mode      in   2            0 PASS, 1 SWAP, 2 IDLE, 3 TEST (registered once)
//   err_clr   in   1            pulse: clear all rx_err bits
//   cnt_clr   in   1            pulse: clear all edge counters
//   rx_p      in   NCH          positive rx lines, asynchronous
//   rx_n      in   NCH          negative rx lines, asynchronous
//   tx_p      out  NCH          positive tx lines, registered
//   tx_n      out  NCH          negative tx lines, registered
//   rx_err    out  NCH          sticky invalid-state flag per channel
//   edge_cnt  out  NCH*CNT_W    rising-edge count, ch i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module passthru_mc #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 10,
    parameter int DIV_W       = 10
) (
    input  logic                 fxclk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 err_clr,
    input  logic                 cnt_clr,
    input  logic [NCH-1:0]       rx_p,
    input  logic [NCH-1:0]       rx_n,
    output logic [NCH-1:0]       tx_p,
    output logic [NCH-1:0]       tx_n,
    output logic [NCH-1:0]       rx_err,
    output logic [NCH*CNT_W-1:0] edge_cnt
);

    // p and n lines are handled as one vector of 2*NCH lines: p in the low
    // half, n in the high half.
    localparam int NL = 2 * NCH;
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SWAP = 2'd1,
        MODE_IDLE = 2'd2,
        MODE_TEST = 2'd3
    } mode_t;

    logic [SYNC_STAGES-1:0][NL-1:0] sync;
    logic [NL-1:0]                  s;
    logic [NL-1:0]                  f;
    logic [NL-1:0]                  f_next;
    logic [NL-1:0][CW-1:0]          c;
    logic [NL-1:0][CW-1:0]          c_next;
    logic [NCH-1:0]                 f_p;
    logic [NCH-1:0]                 f_n;
    logic [NCH-1:0]                 rise;
    logic [NCH-1:0][CNT_W-1:0]      cnt;
    mode_t                          mreg;
    logic [DIV_W-1:0]               presc;
    logic                           tbit;
    logic [NCH-1:0]                 tx_p_d;
    logic [NCH-1:0]                 tx_n_d;

    assign s   = sync[SYNC_STAGES-1];
    assign f_p = f[NCH-1:0];
    assign f_n = f[NL-1:NCH];

    // Filter: a level change is accepted only after s has differed from f on
    // FILT_LEN consecutive edges; any agreement restarts the count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves a value unassigned and no latch forms.
        f_next = f;
        c_next = '0;
        for (int i = 0; i < NL; i++) begin
            if (s[i] != f[i]) begin
                if (c[i] == CW'(FILT_LEN - 1)) begin
                    f_next[i] = s[i];
                end else begin
                    c_next[i] = c[i] + CW'(1);
                end
            end
        end
    end

    // The counter advances on the same edge the filtered p level rises.
    assign rise = ~f_p & f_next[NCH-1:0];

    always_comb begin
        tx_p_d = '0;
        tx_n_d = '0;
        case (mreg)
            MODE_PASS: begin tx_p_d = f_p;          tx_n_d = f_n;           end
            MODE_SWAP: begin tx_p_d = f_n;          tx_n_d = f_p;           end
            MODE_IDLE: begin tx_p_d = '0;           tx_n_d = '0;            end
            MODE_TEST: begin tx_p_d = {NCH{tbit}};  tx_n_d = {NCH{~tbit}};  end
            default:   begin tx_p_d = '0;           tx_n_d = '0;            end
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge fxclk) begin
        if (!reset_n) begin
            // NOTE: the filter counters and edge counters are per-channel
            // arrays, yet all are cleared here so a reset mid-filter restarts
            // every channel from a known state.
            sync   <= '0;
            f      <= '0;
            c      <= '0;
            cnt    <= '0;
            rx_err <= '0;
            tx_p   <= '0;
            tx_n   <= '0;
            presc  <= '0;
            tbit   <= 1'b0;
            mreg   <= MODE_PASS;
        end else begin
            sync[0] <= {rx_n, rx_p};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end

            f <= f_next;
            c <= c_next;

            mreg <= mode_t'(mode);
            tx_p <= tx_p_d;
            tx_n <= tx_n_d;

            presc <= presc + DIV_W'(1);
            if (&presc) begin
                tbit <= ~tbit;
            end

            // A fresh fault outranks a clear issued in the same cycle.
            rx_err <= (rx_err & ~{NCH{err_clr}}) | (f_p ~^ f_n);

            for (int i = 0; i < NCH; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (rise[i] && !(&cnt[i])) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign edge_cnt = cnt;

endmodule

// File: tb/tb_passthru_mc.sv
// -----------------------------------------------------------------------------
// tb_passthru_mc
//   Scoreboard bench for passthru_mc (NCH=2, SYNC_STAGES=2, FILT_LEN=3,
//   CNT_W=3, DIV_W=2). Stimulus pushes expected observations stamped with the
//   cycle they must appear on; a monitor on the falling edge pops and compares.
//   Observation word: {tx_p[1:0], tx_n[1:0], rx_err[1:0], cnt1[2:0], cnt0[2:0]}.
// -----------------------------------------------------------------------------
module tb_passthru_mc;

    localparam int NCH   = 2;
    localparam int CNT_W = 3;

    localparam logic [11:0] M_TXP  = 12'hC00;
    localparam logic [11:0] M_TXN  = 12'h300;
    localparam logic [11:0] M_ERR  = 12'h0C0;
    localparam logic [11:0] M_CNT1 = 12'h038;
    localparam logic [11:0] M_CNT0 = 12'h007;
    localparam logic [11:0] M_ALL  = 12'hFFF;

    logic                 fxclk = 1'b0;
    logic                 reset_n;
    logic [1:0]           mode;
    logic                 err_clr;
    logic                 cnt_clr;
    logic [NCH-1:0]       rx_p;
    logic [NCH-1:0]       rx_n;
    logic [NCH-1:0]       tx_p;
    logic [NCH-1:0]       tx_n;
    logic [NCH-1:0]       rx_err;
    logic [NCH*CNT_W-1:0] edge_cnt;

    passthru_mc #(
        .NCH(NCH), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CNT_W), .DIV_W(2)
    ) dut (
        .fxclk(fxclk), .reset_n(reset_n), .mode(mode), .err_clr(err_clr),
        .cnt_clr(cnt_clr), .rx_p(rx_p), .rx_n(rx_n), .tx_p(tx_p), .tx_n(tx_n),
        .rx_err(rx_err), .edge_cnt(edge_cnt)
    );

    always #5 fxclk = ~fxclk;

    int cyc = 0;
    always @(posedge fxclk) cyc++;

    typedef struct {
        int          cyc;
        logic [11:0] mask;
        logic [11:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rel_cyc;

    logic [11:0] obs;
    assign obs = {tx_p, tx_n, rx_err, edge_cnt};

    function automatic logic [11:0] ob(input logic [1:0] tp, input logic [1:0] tn,
                                       input logic [1:0] er, input logic [2:0] c1,
                                       input logic [2:0] c0);
        return {tp, tn, er, c1, c0};
    endfunction

    // Queue an expectation dly cycles from now, kept in cycle order.
    task automatic expect_at(input int dly, input logic [11:0] mask,
                             input logic [11:0] val, input string name);
        exp_t e;
        int   i;
        e.cyc  = cyc + dly;
        e.mask = mask;
        e.val  = val & mask;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: compare every expectation due on this cycle.
    always @(negedge fxclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, obs & e.mask, e.val);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge fxclk);
            #1;
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 2'd0;
        err_clr = 1'b0;
        cnt_clr = 1'b0;
        rx_p    = 2'b00;
        rx_n    = 2'b11;
        step(3);
        expect_at(0, M_ALL, 12'h000, "reset_state");

        // Release and let both channels settle to p=0, n=1.
        reset_n = 1'b1;
        rel_cyc = cyc;
        step(10);
        pulse_err_clr();
        expect_at(0, M_ALL, ob(2'b00, 2'b11, 2'b00, 3'd0, 3'd0), "settled");

        // Scenario 1: PASS latency, 6 edges.
        rx_p = 2'b01;
        rx_n = 2'b10;
        expect_at(5, M_TXP | M_TXN, ob(2'b00, 2'b11, 2'b00, 3'd0, 3'd0), "pass_lat5");
        expect_at(6, M_ALL, ob(2'b01, 2'b10, 2'b00, 3'd0, 3'd1), "pass_lat6");
        step(10);

        // Scenario 2: 2-cycle glitch is swallowed.
        rx_p = 2'b11;
        step(2);
        rx_p = 2'b01;
        expect_at(4, M_ALL, ob(2'b01, 2'b10, 2'b00, 3'd0, 3'd1), "glitch2_a");
        expect_at(7, M_ALL, ob(2'b01, 2'b10, 2'b00, 3'd0, 3'd1), "glitch2_b");
        step(10);

        // 3-cycle pulse passes; p==n on ch1 raises its error flag.
        rx_p = 2'b11;
        expect_at(6, M_ALL, ob(2'b11, 2'b10, 2'b10, 3'd1, 3'd1), "pulse3_on");
        expect_at(8, M_TXP, ob(2'b11, 2'b00, 2'b00, 3'd0, 3'd0), "pulse3_hold");
        step(3);
        rx_p = 2'b01;
        expect_at(6, M_ALL, ob(2'b01, 2'b10, 2'b10, 3'd1, 3'd1), "pulse3_off");
        step(8);
        pulse_err_clr();
        expect_at(0, M_ERR, 12'h000, "err_clr_ch1");

        // Scenario 3: modes.
        mode = 2'd1;
        expect_at(1, M_TXP | M_TXN, ob(2'b01, 2'b10, 2'b00, 3'd0, 3'd0), "mode_lag");
        expect_at(2, M_TXP | M_TXN, ob(2'b10, 2'b01, 2'b00, 3'd0, 3'd0), "swap");
        step(3);
        mode = 2'd2;
        expect_at(2, M_TXP | M_TXN, 12'h000, "idle");
        step(3);
        mode = 2'd3;
        for (int d = 2; d < 10; d++) begin
            int   k;
            logic t;
            k = cyc + d - rel_cyc;
            t = logic'(((k - 1) / 4) % 2);
            expect_at(d, M_TXP | M_TXN, ob({2{t}}, {2{~t}}, 2'b00, 3'd0, 3'd0), "test_pat");
        end
        step(10);

        // Scenario 6: reset mid-filter in TEST, then PASS latency again.
        rx_p = 2'b00;
        step(3);
        reset_n = 1'b0;
        expect_at(1, M_ALL, 12'h000, "reset_mid");
        step(1);
        rx_p = 2'b01;
        rx_n = 2'b10;
        mode = 2'd0;
        step(1);
        reset_n = 1'b1;
        rel_cyc = cyc;
        expect_at(5, M_TXP | M_TXN, 12'h000, "rst_lat5");
        expect_at(6, M_ALL, ob(2'b01, 2'b10, 2'b11, 3'd0, 3'd1), "rst_lat6");
        step(10);
        pulse_err_clr();
        expect_at(0, M_ERR, 12'h000, "err_clr_post_rst");

        // Scenario 4: sticky error and set-wins-over-clear.
        rx_n = 2'b11;
        expect_at(6, M_ERR | M_TXN, ob(2'b00, 2'b11, 2'b01, 3'd0, 3'd0), "err_set");
        step(5);
        rx_n = 2'b10;
        step(1);
        pulse_err_clr();
        expect_at(0, M_ERR, ob(2'b00, 2'b00, 2'b01, 3'd0, 3'd0), "err_set_wins");
        step(6);
        expect_at(0, M_ERR, ob(2'b00, 2'b00, 2'b01, 3'd0, 3'd0), "err_sticky");
        pulse_err_clr();
        expect_at(0, M_ERR, 12'h000, "err_cleared");

        // Scenario 5: saturation, then clear colliding with an edge.
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        expect_at(0, M_CNT1 | M_CNT0, 12'h000, "cnt_clr");
        for (int r = 0; r < 9; r++) begin
            rx_p = 2'b00;
            rx_n = 2'b11;
            step(4);
            rx_p = 2'b01;
            rx_n = 2'b10;
            step(4);
        end
        step(4);
        expect_at(0, M_ALL, ob(2'b01, 2'b10, 2'b00, 3'd0, 3'd7), "cnt_sat");
        rx_p = 2'b00;
        rx_n = 2'b11;
        step(8);
        rx_p = 2'b01;
        rx_n = 2'b10;
        step(4);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        expect_at(0, M_CNT0, 12'h000, "clr_wins");
        expect_at(1, M_CNT0 | M_TXP, ob(2'b01, 2'b00, 2'b00, 3'd0, 3'd0), "clr_wins_tx");
        step(3);

        // Anything still queued was never observed.
        repeat (5) @(negedge fxclk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for cyc %0d never compared (now %0d)",
                     e.name, e.cyc, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
